stage_wb_pipe: RTL

- Parametrised writeback stage for the RISC-V core.
- Absorbs the MEM/WB pipeline register as a one-entry valid/ready buffer.
- Selects among four result sources, formats load data (byte/half/word, signed/unsigned), and waits for late memory responses.
- Drives the register-file write port, flags load timeouts, and counts retired instructions.

---
 rtl/stage_wb_pipe_if.sv | 47 ++++
 rtl/stage_wb_pipe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/stage_wb_pipe_if.sv
// Writeback stage bus: MEM/WB handshake, late load response, register-file
// write port and status.
//
// Handshake: a transfer happens on a rising clk edge where in_valid and
// in_ready are both 1. While in_valid is 1 the producer holds the in_*
// payload stable until that transfer. in_ready may depend combinationally on
// flush and mem_rsp_valid in the same cycle. mem_rsp_valid is a one-cycle
// strobe with no back-pressure.
interface stage_wb_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_regwrite;
  logic [4:0]       in_rd;
  logic [1:0]       in_wbsel;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_pc4;
  logic [XLEN-1:0]  in_aux;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_data;
  logic             flush;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             wb_busy;
  logic             wb_load_timeout;
  logic [CNT_W-1:0] retired_count;
  logic [1:0]       dbg_state;   // 0 EMPTY, 1 HOLD, 2 WAIT

  modport master (
    output in_valid, in_regwrite, in_rd, in_wbsel, in_funct3, in_addr_lo,
           in_alu_result, in_pc4, in_aux, mem_rsp_valid, mem_rsp_data, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, wb_busy, wb_load_timeout,
           retired_count, dbg_state
  );

  modport slave (
    input  in_valid, in_regwrite, in_rd, in_wbsel, in_funct3, in_addr_lo,
           in_alu_result, in_pc4, in_aux, mem_rsp_valid, mem_rsp_data, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, wb_busy, wb_load_timeout,
           retired_count, dbg_state
  );
endinterface

// File: rtl/stage_wb_pipe.sv
// RISC-V writeback stage: one-entry MEM/WB buffer, result select, load
// formatting, late-load wait with sticky timeout, retired counter.
module stage_wb_pipe #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  stage_wb_pipe_if.slave bus
);

  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CMAX = (TIMEOUT > 0) ? TIMEOUT : 1;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_HOLD = 2'd1, S_WAIT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             regwrite_q;
  logic [4:0]       rd_q;
  logic [1:0]       wbsel_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [XLEN-1:0]  alu_q, pc4_q, aux_q;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             occupied, retire, accept, in_ready;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  load_fmt, result;

  // Retire/accept decisions; a load entry is exactly the WAIT state, so stray
  // responses in other states have no effect.
  always_comb begin
    occupied = (state_q != S_EMPTY);
    retire   = occupied && !bus.flush && (wbsel_q != 2'd1 || bus.mem_rsp_valid);
    in_ready = !bus.flush && (!occupied || retire);
    accept   = bus.in_valid && in_ready;
  end

  // Next state, wait counter, sticky timeout and retired counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    retired_d  = retired_q;
    if (bus.flush) begin
      state_d    = S_EMPTY;
      wait_cnt_d = '0;
    end else begin
      if (retire) retired_d = retired_q + 1'b1;
      if (accept) begin
        state_d    = (bus.in_wbsel == 2'd1) ? S_WAIT : S_HOLD;
        wait_cnt_d = '0;
      end else if (retire) begin
        state_d = S_EMPTY;
      end else if (state_q == S_WAIT && wait_cnt_q != CW'(CMAX)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    if (TIMEOUT > 0 && wait_cnt_d == CW'(CMAX)) timeout_d = 1'b1;
  end

  // State, counters and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      retired_q  <= retired_d;
    end
  end

  // Payload capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbsel_q    <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      aux_q      <= '0;
    end else if (accept) begin
      regwrite_q <= bus.in_regwrite;
      rd_q       <= bus.in_rd;
      wbsel_q    <= bus.in_wbsel;
      funct3_q   <= bus.in_funct3;
      addr_lo_q  <= bus.in_addr_lo;
      alu_q      <= bus.in_alu_result;
      pc4_q      <= bus.in_pc4;
      aux_q      <= bus.in_aux;
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = bus.mem_rsp_data[7:0];
      2'd1:    ld_byte = bus.mem_rsp_data[15:8];
      2'd2:    ld_byte = bus.mem_rsp_data[23:16];
      default: ld_byte = bus.mem_rsp_data[31:24];
    endcase
    ld_half = addr_lo_q[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    case (funct3_q)
      3'b000:  load_fmt = XLEN'(signed'(ld_byte));
      3'b100:  load_fmt = XLEN'(ld_byte);
      3'b001:  load_fmt = XLEN'(signed'(ld_half));
      3'b101:  load_fmt = XLEN'(ld_half);
      3'b010:  load_fmt = XLEN'(signed'(bus.mem_rsp_data[31:0]));
      default: load_fmt = bus.mem_rsp_data;
    endcase
  end

  // Result source select.
  always_comb begin
    case (wbsel_q)
      2'd0:    result = alu_q;
      2'd1:    result = load_fmt;
      2'd2:    result = pc4_q;
      default: result = aux_q;
    endcase
  end

  assign bus.in_ready        = in_ready;
  assign bus.rf_we           = retire && regwrite_q && (rd_q != 5'd0);
  assign bus.rf_waddr        = occupied ? rd_q : 5'd0;
  assign bus.rf_wdata        = occupied ? result : '0;
  assign bus.wb_busy         = (state_q == S_WAIT);
  assign bus.wb_load_timeout = timeout_q;
  assign bus.retired_count   = retired_q;
  assign bus.dbg_state       = state_q;

endmodule
